// File: rtl/ibus_prefetch_queue_if.sv
// ----------------------------------------------------------------------------
// ibus_prefetch_queue_if
//   Signal bundle between the instruction prefetch queue, the fetch stage and
//   the instruction bus.
//
//   Core side : redirect, redirect_pc, instr_ready  -> queue
//               instr_valid, instr, instr_pc        <- queue
//   Bus side  : mreq_valid, mreq_addr               <- queue
//               mresp_addr_ok, mresp_data_ok,
//               mresp_data                          -> queue
//
//   modport master : view taken by the prefetch queue itself
//   modport slave  : view taken by the environment (core + bus)
// ----------------------------------------------------------------------------
interface ibus_prefetch_queue_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        mreq_valid;
  logic [31:0] mreq_addr;
  logic        mresp_addr_ok;
  logic        mresp_data_ok;
  logic [31:0] mresp_data;

  modport master (
    input  redirect, redirect_pc, instr_ready,
    input  mresp_addr_ok, mresp_data_ok, mresp_data,
    output instr_valid, instr, instr_pc,
    output mreq_valid, mreq_addr
  );

  modport slave (
    output redirect, redirect_pc, instr_ready,
    output mresp_addr_ok, mresp_data_ok, mresp_data,
    input  instr_valid, instr, instr_pc,
    input  mreq_valid, mreq_addr
  );
endinterface

// File: rtl/ibus_prefetch_queue.sv
// ----------------------------------------------------------------------------
// ibus_prefetch_queue
//   Instruction prefetcher: issues sequential word fetches on the instruction
//   bus (one outstanding at a time), buffers returned words with their PC in a
//   DEPTH-entry FIFO and presents the head to the fetch stage via valid/ready.
//   A redirect empties the FIFO, restarts fetching at the new PC and squashes
//   whatever fetch is in flight.
//
//   Ports:
//     clk    - clock, all state changes on posedge
//     reset  - asynchronous, active-high
//     bus    - ibus_prefetch_queue_if.master (core handshake + bus request)
// ----------------------------------------------------------------------------
module ibus_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  ibus_prefetch_queue_if.master  bus
);

  localparam int             PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DISCARD} state_t;

  state_t           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      req_pc_q, req_pc_d;
  logic             stale_q, stale_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

  logic             push;
  logic             pop;
  logic [31:0]      slot_data [DEPTH];
  logic [31:0]      slot_pc   [DEPTH];

  // Low address bits of the redirect target are deliberately discarded.
  logic             unused_ok;
  assign unused_ok = &{1'b0, bus.redirect_pc[1:0]};

  // Redirect wins over a pop: the head being consumed is flushed anyway.
  assign pop = (count_q != '0) && bus.instr_ready && !bus.redirect;

  // --------------------------------------------------------------------------
  // Fetch FSM, next-state and request bookkeeping
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    stale_d    = stale_q;
    push       = 1'b0;

    case (state_q)
      IDLE: begin
        // Issue is gated on a free slot so the single outstanding fetch can
        // always be absorbed; a concurrent pop is not credited.
        if (!bus.redirect && (count_q != FULL_CNT)) begin
          state_d  = REQ;
          req_pc_d = fetch_pc_q;
        end
      end
      REQ: begin
        if (bus.mresp_addr_ok) begin
          if (stale_q || bus.redirect) begin
            state_d = DISCARD;
          end else begin
            state_d    = WAIT;
            fetch_pc_d = req_pc_q + 32'd4;
          end
        end else if (bus.redirect) begin
          // The bus request cannot be withdrawn; remember to drop its data.
          stale_d = 1'b1;
        end
      end
      WAIT: begin
        if (bus.mresp_data_ok) begin
          state_d = IDLE;
          push    = !bus.redirect;
        end else if (bus.redirect) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (bus.mresp_data_ok) begin
          state_d = IDLE;
          stale_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.redirect) begin
      fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
    end
  end

  // --------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // --------------------------------------------------------------------------
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= {RESET_PC[31:2], 2'b00};
      req_pc_q   <= '0;
      stale_q    <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      stale_q    <= stale_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // --------------------------------------------------------------------------
  // Storage slots: registered so the head never sees mresp_data directly.
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [31:0] data_q;
    logic [31:0] pc_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        data_q <= '0;
        pc_q   <= '0;
      end else if (push && (wr_ptr_q == PTR_W'(gi))) begin
        data_q <= bus.mresp_data;
        pc_q   <= req_pc_q;
      end
    end

    assign slot_data[gi] = data_q;
    assign slot_pc[gi]   = pc_q;
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.instr_valid = (count_q != '0);
  assign bus.instr       = slot_data[rd_ptr_q];
  assign bus.instr_pc    = slot_pc[rd_ptr_q];
  assign bus.mreq_valid  = (state_q == REQ);
  assign bus.mreq_addr   = req_pc_q;

endmodule
